// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote sampling, per-frame error flags and
// a first-word-fall-through receive FIFO. Optional break detection: UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uart_rx,
    output logic [DATA_BITS-1:0]         rx_data,
    output logic                         rx_frame_err,
    output logic                         rx_parity_err,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                         break_det,
`endif
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCW     = ($clog2(OVERSAMPLE) < 4) ? 4 : $clog2(OVERSAMPLE);
    localparam int BCW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = DATA_BITS + 2;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] SMP_A     = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] SMP_B     = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] SMP_C     = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // ------------------------------------------------------------------
    // Receive FSM, tick divider and bit sampler
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [TCW-1:0]        tcnt_q;
    logic [BCW-1:0]        bcnt_q;
    logic [1:0]            smp_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_err_q;

    logic                  active;
    logic                  tick;
    logic                  dec;
    logic                  maj;
    logic                  par_exp;
    logic                  stop_dec;
    logic                  is_break;
    logic                  push;
    logic [EW-1:0]         push_entry;

    assign active   = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign tick     = active && (div_q == DIV_LAST);
    assign dec      = tick && (tcnt_q == SMP_C);
    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign par_exp  = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    assign stop_dec = (state_q == S_STOP) && dec;
    // Start bit was already 0, so an all-zero payload plus a low stop bit is a line break.
    assign is_break = stop_dec && !maj && (shift_q == '0);

`ifdef UART_RX_BREAK_DETECT_EN
    assign push = stop_dec && !is_break;
`else
    assign push = stop_dec;
`endif

    assign push_entry = {~maj, par_err_q, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (!active) begin
                div_q  <= '0;
                tcnt_q <= '0;
            end else if (tick) begin
                div_q  <= '0;
                tcnt_q <= (tcnt_q == TICK_LAST) ? '0 : tcnt_q + 1'b1;
                if (tcnt_q == SMP_A) begin
                    smp_q[0] <= rx_s;
                end
                if (tcnt_q == SMP_B) begin
                    smp_q[1] <= rx_s;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q   <= S_START;
                        bcnt_q    <= '0;
                        par_err_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (dec) begin
                        state_q <= maj ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (dec) begin
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == BIT_LAST) begin
                            bcnt_q  <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (dec) begin
                        par_err_q <= (maj != par_exp);
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (dec) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    // A line held low after the frame must not start a new one.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic break_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_q <= 1'b0;
        end else begin
            break_q <= is_break;
        end
    end

    assign break_det = break_q;
`endif

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  cnt_q;
    logic           ovr_q;

    logic           full;
    logic           pop;
    logic           wr_en;
    logic [EW-1:0]  head;

    assign full  = (cnt_q == FULL_CNT);
    assign pop   = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= push && full && !pop;
            if (wr_en) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head          = mem_q[rd_q];
    assign rx_valid      = (cnt_q != '0);
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_valid & head[EW-1];
    assign rx_parity_err = rx_valid & head[EW-2] & (PARITY != 0);
    assign overrun       = ovr_q;
    assign fifo_count    = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: one default-rate instance, one fast
// 8N1 instance and one fast even-parity instance, driven bit by bit on the falling edge.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BCLK_SLOW = 1250;  // 104167 ns per bit at 12 MHz
    localparam int BCLK_FAST = 112;   // 115200 baud: DIV 7 x 16

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;

    always #41.667 clk = ~clk;

    logic       line    [3];
    logic       ready   [3];
    logic [7:0] data_w  [3];
    logic       fe_w    [3];
    logic       pe_w    [3];
    logic       valid_w [3];
    logic       ovr_w   [3];
    logic [2:0] cnt_w   [3];
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_w   [3];
    int         brk_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt1 = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[0]),
        .rx_data(data_w[0]), .rx_frame_err(fe_w[0]), .rx_parity_err(pe_w[0]),
        .rx_valid(valid_w[0]), .rx_ready(ready[0]), .overrun(ovr_w[0]),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det(brk_w[0]),
`endif
        .fifo_count(cnt_w[0])
    );

    uart_rx_fifo #(.BAUD(115200)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[1]),
        .rx_data(data_w[1]), .rx_frame_err(fe_w[1]), .rx_parity_err(pe_w[1]),
        .rx_valid(valid_w[1]), .rx_ready(ready[1]), .overrun(ovr_w[1]),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det(brk_w[1]),
`endif
        .fifo_count(cnt_w[1])
    );

    uart_rx_fifo #(.BAUD(115200), .PARITY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[2]),
        .rx_data(data_w[2]), .rx_frame_err(fe_w[2]), .rx_parity_err(pe_w[2]),
        .rx_valid(valid_w[2]), .rx_ready(ready[2]), .overrun(ovr_w[2]),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det(brk_w[2]),
`endif
        .fifo_count(cnt_w[2])
    );

    always @(negedge clk) begin
        if (ovr_w[1] === 1'b1) ovr_cnt1++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_w[1] === 1'b1) brk_cnt++;
`endif
    end

    // ---------------- driver tasks ----------------
    // Sends start, data (LSB first), optional parity, stop and one idle-high bit.
    // chg_at: first negedge index where fifo_count differs from its starting value.
    // pulse_at: negedge index at which rx_ready is raised for exactly one cycle.
    task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                              input bit has_par, input logic pb, input logic stop,
                              input int bclk, input int pulse_at, output int chg_at);
        logic [15:0] lv;
        logic [2:0]  c0;
        int          n;
        int          idx;
        lv = '1;
        n  = 0;
        lv[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            lv[n] = d[i]; n++;
        end
        if (has_par) begin
            lv[n] = pb; n++;
        end
        lv[n] = stop; n++;
        lv[n] = 1'b1; n++;
        c0     = cnt_w[w];
        chg_at = -1;
        idx    = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < bclk; k++) begin
                @(negedge clk);
                if (chg_at < 0 && cnt_w[w] !== c0) chg_at = idx;
                line[w]  = lv[b];
                ready[w] = (idx == pulse_at);
                idx++;
            end
        end
        @(negedge clk);
        line[w]  = 1'b1;
        ready[w] = 1'b0;
    endtask

    task automatic pop(input int w);
        @(negedge clk);
        ready[w] = 1'b1;
        @(negedge clk);
        ready[w] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            line[i]  = 1'b1;
            ready[i] = 1'b0;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (valid_w[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid dut%0d: got %b expected 0", i, valid_w[i]);
            end
            n_checks++;
            if (cnt_w[i] !== 3'd0) begin
                n_fail++; $display("FAIL reset_count dut%0d: got %0d expected 0", i, cnt_w[i]);
            end
        end
        n_checks++;
        if (data_w[0] !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", data_w[0]);
        end
        n_checks++;
        if ({fe_w[0], pe_w[0], ovr_w[0]} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {fe_w[0], pe_w[0], ovr_w[0]});
        end
`ifdef UART_RX_BREAK_DETECT_EN
        n_checks++;
        if (brk_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_break: got %b expected 0", brk_w[0]);
        end
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_false_start();
        for (int k = 0; k < (BCLK_SLOW * 3) / 10; k++) begin
            @(negedge clk); line[0] = 1'b0;
        end
        for (int k = 0; k < 2 * BCLK_SLOW; k++) begin
            @(negedge clk); line[0] = 1'b1;
        end
        n_checks++;
        if (cnt_w[0] !== 3'd0 || valid_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL false_start: got count %0d valid %b expected 0 0", cnt_w[0], valid_w[0]);
        end
    endtask

    task automatic test_basic();
        int chg;
        send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1'b1, BCLK_SLOW, -1, chg);
        n_checks++;
        if (chg < 0) begin
            n_fail++; $display("FAIL basic_push_seen: got no count change expected one");
        end
        send_frame(0, 9'h043, 8, 1'b0, 1'b0, 1'b1, BCLK_SLOW, -1, chg);
        repeat (2) @(negedge clk);
        n_checks++;
        if (cnt_w[0] !== 3'd2) begin
            n_fail++; $display("FAIL basic_count2: got %0d expected 2", cnt_w[0]);
        end
        n_checks++;
        if (valid_w[0] !== 1'b1 || data_w[0] !== 8'h42) begin
            n_fail++; $display("FAIL basic_head1: got valid %b data %h expected 1 42", valid_w[0], data_w[0]);
        end
        n_checks++;
        if ({fe_w[0], pe_w[0]} !== 2'b00) begin
            n_fail++; $display("FAIL basic_flags: got %b expected 00", {fe_w[0], pe_w[0]});
        end
        pop(0);
        n_checks++;
        if (data_w[0] !== 8'h43 || cnt_w[0] !== 3'd1) begin
            n_fail++; $display("FAIL basic_head2: got data %h count %0d expected 43 1", data_w[0], cnt_w[0]);
        end
        pop(0);
        n_checks++;
        if (valid_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) begin
            n_fail++; $display("FAIL basic_drained: got valid %b count %0d expected 0 0", valid_w[0], cnt_w[0]);
        end
        // rx_ready while empty must not underflow the count
        pop(0);
        n_checks++;
        if (cnt_w[0] !== 3'd0) begin
            n_fail++; $display("FAIL empty_pop: got count %0d expected 0", cnt_w[0]);
        end
    endtask

    task automatic test_parity();
        int chg;
        // 0xA5 has four ones: even parity bit is 0, so 1 is wrong
        send_frame(2, 9'h0A5, 8, 1'b1, 1'b1, 1'b1, BCLK_FAST, -1, chg);
        n_checks++;
        if (valid_w[2] !== 1'b1 || data_w[2] !== 8'hA5 || pe_w[2] !== 1'b1 || fe_w[2] !== 1'b0) begin
            n_fail++; $display("FAIL parity_bad: got v%b d%h pe%b fe%b expected v1 dA5 pe1 fe0",
                               valid_w[2], data_w[2], pe_w[2], fe_w[2]);
        end
        pop(2);
        send_frame(2, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, BCLK_FAST, -1, chg);
        n_checks++;
        if (valid_w[2] !== 1'b1 || data_w[2] !== 8'hA5 || pe_w[2] !== 1'b0) begin
            n_fail++; $display("FAIL parity_good: got v%b d%h pe%b expected v1 dA5 pe0",
                               valid_w[2], data_w[2], pe_w[2]);
        end
        pop(2);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 5 * BCLK_FAST; k++) begin
            @(negedge clk); line[1] = 1'b0;
        end
        rst_n   = 1'b0;
        line[1] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BCLK_FAST) @(negedge clk);
        n_checks++;
        if (cnt_w[1] !== 3'd0 || valid_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_frame: got count %0d valid %b expected 0 0", cnt_w[1], valid_w[1]);
        end
    endtask

    task automatic test_frame_err();
        int chg;
        send_frame(1, 9'h055, 8, 1'b0, 1'b0, 1'b0, BCLK_FAST, -1, chg);
        n_checks++;
        if (valid_w[1] !== 1'b1 || data_w[1] !== 8'h55 || fe_w[1] !== 1'b1 || pe_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL frame_err: got v%b d%h fe%b pe%b expected v1 d55 fe1 pe0",
                               valid_w[1], data_w[1], fe_w[1], pe_w[1]);
        end
        pop(1);
        send_frame(1, 9'h00F, 8, 1'b0, 1'b0, 1'b1, BCLK_FAST, -1, chg);
        n_checks++;
        if (valid_w[1] !== 1'b1 || data_w[1] !== 8'h0F || fe_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL frame_recover: got v%b d%h fe%b expected v1 d0F fe0",
                               valid_w[1], data_w[1], fe_w[1]);
        end
        pop(1);
    endtask

    task automatic test_overrun();
        int chg;
        int chg4;
        logic [7:0] e;
        chg4 = -1;
        for (int i = 1; i <= 4; i++) begin
            send_frame(1, 9'(i), 8, 1'b0, 1'b0, 1'b1, BCLK_FAST, -1, chg);
            if (i == 4) chg4 = chg;
        end
        n_checks++;
        if (cnt_w[1] !== 3'd4 || ovr_cnt1 != 0) begin
            n_fail++; $display("FAIL fill_four: got count %0d overruns %0d expected 4 0", cnt_w[1], ovr_cnt1);
        end
        send_frame(1, 9'h005, 8, 1'b0, 1'b0, 1'b1, BCLK_FAST, -1, chg);
        n_checks++;
        if (cnt_w[1] !== 3'd4 || ovr_cnt1 != 1) begin
            n_fail++; $display("FAIL overrun_once: got count %0d overruns %0d expected 4 1", cnt_w[1], ovr_cnt1);
        end
        n_checks++;
        if (data_w[1] !== 8'h01) begin
            n_fail++; $display("FAIL overrun_head: got %h expected 01", data_w[1]);
        end
        n_checks++;
        if (chg4 < 1) begin
            n_fail++; $display("FAIL push_timing: got %0d expected a positive index", chg4);
        end
        // Replay the same frame timing with rx_ready in the push cycle of a full FIFO.
        send_frame(1, 9'h006, 8, 1'b0, 1'b0, 1'b1, BCLK_FAST, chg4 - 1, chg);
        n_checks++;
        if (cnt_w[1] !== 3'd4 || ovr_cnt1 != 1 || chg != -1) begin
            n_fail++; $display("FAIL full_push_pop: got count %0d overruns %0d change_at %0d expected 4 1 -1",
                               cnt_w[1], ovr_cnt1, chg);
        end
        exp_q = {8'h02, 8'h03, 8'h04, 8'h06};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (valid_w[1] !== 1'b1 || data_w[1] !== e) begin
                n_fail++; $display("FAIL drain_order: got v%b d%h expected v1 d%h", valid_w[1], data_w[1], e);
            end
            pop(1);
        end
        n_checks++;
        if (cnt_w[1] !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: got %0d expected 0", cnt_w[1]);
        end
    endtask

    task automatic test_break();
        for (int k = 0; k < 12 * BCLK_FAST; k++) begin
            @(negedge clk); line[1] = 1'b0;
        end
        for (int k = 0; k < 2 * BCLK_FAST; k++) begin
            @(negedge clk); line[1] = 1'b1;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        n_checks++;
        if (brk_cnt != 1) begin
            n_fail++; $display("FAIL break_pulse: got %0d pulses expected 1", brk_cnt);
        end
        n_checks++;
        if (cnt_w[1] !== 3'd0 || ovr_cnt1 != 1) begin
            n_fail++; $display("FAIL break_no_push: got count %0d overruns %0d expected 0 1", cnt_w[1], ovr_cnt1);
        end
`else
        n_checks++;
        if (cnt_w[1] !== 3'd1) begin
            n_fail++; $display("FAIL break_count: got %0d expected 1", cnt_w[1]);
        end
        n_checks++;
        if (data_w[1] !== 8'h00 || fe_w[1] !== 1'b1 || pe_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL break_entry: got d%h fe%b pe%b expected d00 fe1 pe0",
                               data_w[1], fe_w[1], pe_w[1]);
        end
        pop(1);
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_false_start();
        test_basic();
        test_parity();
        test_reset_mid_frame();
        test_frame_err();
        test_overrun();
        test_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got no completion expected finish before 20 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver that feeds the display row/column logic. Adds the following over the fixed receiver:
- configurable data width and parity
- oversampled majority-vote bit sampling
- per-byte error flags
- a small first-word-fall-through receive FIFO with a valid/ready handshake toward the display/command decoder

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, payload bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 4, receive FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  head-of-FIFO payload
rx_frame_err  out  1  head entry: stop bit sampled low
rx_parity_err  out  1  head entry: parity mismatch; always 0 when PARITY = 0
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts the head entry
overrun  out  1  one-cycle pulse: completed frame dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset:
- rst_n low clears all state asynchronously.
- Both synchroniser flops reset to 1.
- FSM returns to IDLE; tick divider, bit counter, FIFO pointers and count go to 0.
- Outputs after reset: rx_valid = 0, overrun = 0, rx_data = 0, error flags = 0, fifo_count = 0.
- Reset mid-frame discards the partial frame.

Input and tick generation:
- uart_rx passes through a 2-flop synchroniser: 2 cycles of input latency.
- Tick divider DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE)), with DIV >= 1 (78 at defaults).
- The divider produces a one-cycle tick every DIV clocks. It is held at 0 while in IDLE and starts on start-bit detection.
- A 4-bit-minimum tick counter counts 0..OVERSAMPLE-1 within each bit.

Sampling:
- Each bit value is the majority of 3 samples, taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The bit decision is made at tick OVERSAMPLE/2+1.

FSM states:
- IDLE: a synchronised high-to-low transition moves to START.
- START: at the start-bit decision, a majority of 1 is a false start → IDLE with no push. A majority of 0 → DATA.
- DATA: shifts in DATA_BITS bits, LSB first. Then → PARITY if PARITY != 0, else → STOP.
- PARITY: computes the expected parity bit (odd: XOR of data XOR 1; even: XOR of data). Sets parity_err if it differs from the sampled bit. → STOP.
- STOP: at the stop decision, sets frame_err = ~bit and pushes {frame_err, parity_err, data} into the FIFO, then → WAIT_HIGH in the same cycle.
- WAIT_HIGH: waits for the synchronised line to be 1 before returning to IDLE, so a stuck-low line does not re-trigger.
- Frames with errors are still pushed, with their flags set.

FIFO:
- First-word fall-through. rx_data and the flags show the head entry combinationally from storage whenever rx_valid = 1.
- Pop happens when rx_valid && rx_ready.
- Push and pop in the same cycle: count unchanged, both succeed, including when the FIFO is full.
- Push while full without a pop: the frame is dropped, overrun pulses for 1 cycle, FIFO contents are unchanged.
- rx_ready while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH.

Latency:
- The entry becomes visible (rx_valid rises) 1 clk after the stop-bit decision tick.

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined: adds output break_det (1 bit, resets to 0). A frame whose start, all data and stop bits are sampled 0 is not pushed. Instead, break_det pulses for 1 cycle at the stop decision and the FSM goes to WAIT_HIGH; overrun is not affected.
- Undefined: no break_det port. Such a frame is pushed as data 0 with frame_err = 1.

Test Plan:
- Defaults, send 0x42 then 0x43 as 8N1 at 104167 ns/bit, rx_ready = 0 → fifo_count reaches 2. First entry 0x42 with flags 0. After one rx_ready cycle, head is 0x43 and fifo_count = 1.
- Reset: rst_n held low → all outputs reset values. Then a 0.3-bit low glitch on uart_rx → false start, no push, fifo_count stays 0.
- PARITY = 2, send 0xA5 with parity bit 1 (wrong) → entry 0xA5, rx_parity_err = 1. Resend with parity bit 0 → rx_parity_err = 0.
- Stop bit driven 0 on 0x55, then line returns high → entry 0x55, rx_frame_err = 1. Next byte 0x0F decodes cleanly.
- rx_ready = 0, send 5 bytes 0x01..0x05 → fifo_count = 4, overrun pulses exactly once (on 0x05). Drained order is 0x01..0x04. Simultaneous push/pop when full keeps count at 4.
- With UART_RX_BREAK_DETECT_EN, hold the line low for 12 bit times → break_det pulses once, no push. Without the macro: entry 0x00 with rx_frame_err = 1.
